// File: rtl/clock_ctrl_pkg.sv
// Shared types and constants for the run/step/halt clock controller.
package clock_ctrl_pkg;

  // Encoding is consumed directly by the board 7-seg decoder; keep it stable.
  typedef enum logic [1:0] {
    HALT = 2'd0,
    RUN  = 2'd1,
    STEP = 2'd2
  } ctrl_state_t;

  localparam int unsigned STEP_CNT_W = 16;
  localparam int unsigned RATE_SHIFT = 2;

  // Right-shift applied to the base divider count for a given rate select.
  function automatic int unsigned rate_shamt(input logic [1:0] sel);
    return RATE_SHIFT * int'(sel);
  endfunction

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector for a debounced button level.
// A button already held at reset release must be seen low once before
// any edge is reported, so a stuck-high button cannot fire on power-up.
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic rise
);

  logic btn_d;
  logic seen_low;

  // Registered button history plus the "has been released" qualifier.
  always_ff @(posedge clk) begin
    if (!rst) begin
      btn_d    <= 1'b0;
      seen_low <= 1'b0;
    end else begin
      btn_d    <= btn;
      seen_low <= seen_low | ~btn;
    end
  end

  assign rise = btn & ~btn_d & seen_low;

endmodule

// File: rtl/clock_step_ctrl.sv
// Run/step/halt controller producing one-cycle processor clock enables.
// Optional breakpoint compare: define CLOCK_STEP_CTRL_BREAKPOINT_EN.
module clock_step_ctrl
  import clock_ctrl_pkg::*;
#(
  parameter int unsigned N_COUNT  = 25000000,
  parameter int unsigned PC_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run_btn,
  input  logic                  step_btn,
  input  logic                  halt_req,
  input  logic [1:0]            rate_sel,
`ifdef CLOCK_STEP_CTRL_BREAKPOINT_EN
  input  logic [PC_WIDTH-1:0]   pc,
  input  logic [PC_WIDTH-1:0]   bp_addr,
  input  logic                  bp_valid,
  output logic                  bp_hit,
`endif
  output logic                  cpu_en,
  output logic                  cpu_clk_out,
  output logic [1:0]            state,
  output logic [STEP_CNT_W-1:0] step_count
);

  localparam int unsigned CNT_W = (N_COUNT < 1) ? 1 : $clog2(N_COUNT + 1);

  if (PC_WIDTH == 0) begin : g_bad_pc_width
    $error("PC_WIDTH must be non-zero");
  end

  ctrl_state_t      st, st_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] term;
  logic             pulse;
  logic             run_rise;
  logic             step_rise;

`ifdef CLOCK_STEP_CTRL_BREAKPOINT_EN
  logic bp_armed, bp_armed_nxt;
  logic bp_hit_nxt;
`endif

  rise_detect u_run_rise (
    .clk  (clk),
    .rst  (rst),
    .btn  (run_btn),
    .rise (run_rise)
  );

  rise_detect u_step_rise (
    .clk  (clk),
    .rst  (rst),
    .btn  (step_btn),
    .rise (step_rise)
  );

  // Divider terminal count follows rate_sel immediately.
  always_comb begin
    term = CNT_W'(N_COUNT >> rate_shamt(rate_sel));
  end

  // Next-state, divider and pulse decision; halt sources outrank the terminal count.
  always_comb begin
    st_nxt  = st;
    cnt_nxt = cnt;
    pulse   = 1'b0;
`ifdef CLOCK_STEP_CTRL_BREAKPOINT_EN
    bp_hit_nxt   = bp_hit;
    bp_armed_nxt = 1'b0;
`endif
    case (st)
      HALT: begin
        if (!halt_req) begin
          if (run_rise) begin
            st_nxt  = RUN;
            cnt_nxt = '0;
          end else if (step_rise) begin
            st_nxt = STEP;
          end
        end
      end
      STEP: begin
        st_nxt = HALT;
        pulse  = ~halt_req;
      end
      RUN: begin
`ifdef CLOCK_STEP_CTRL_BREAKPOINT_EN
        // Arm only once the processor has consumed an enable since entry,
        // so resuming from a breakpoint PC is not caught by the stale match.
        bp_armed_nxt = bp_armed | cpu_en;
`endif
        if (halt_req || run_rise) begin
          st_nxt  = HALT;
          cnt_nxt = '0;
`ifdef CLOCK_STEP_CTRL_BREAKPOINT_EN
        end else if (bp_armed && bp_valid && (pc == bp_addr)) begin
          st_nxt     = HALT;
          cnt_nxt    = '0;
          bp_hit_nxt = 1'b1;
`endif
        end else if (cnt >= term) begin
          cnt_nxt = '0;
          pulse   = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        st_nxt  = HALT;
        cnt_nxt = '0;
      end
    endcase
`ifdef CLOCK_STEP_CTRL_BREAKPOINT_EN
    if (st == HALT && st_nxt != HALT) begin
      bp_hit_nxt = 1'b0;
    end
`endif
  end

  // Registered FSM, divider and pulse-driven indicators.
  always_ff @(posedge clk) begin
    if (!rst) begin
      st          <= HALT;
      cnt         <= '0;
      cpu_en      <= 1'b0;
      cpu_clk_out <= 1'b0;
      step_count  <= '0;
    end else begin
      st     <= st_nxt;
      cnt    <= cnt_nxt;
      cpu_en <= pulse;
      if (pulse) begin
        cpu_clk_out <= ~cpu_clk_out;
        step_count  <= step_count + 1'b1;
      end
    end
  end

`ifdef CLOCK_STEP_CTRL_BREAKPOINT_EN
  // Breakpoint arming and sticky hit flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      bp_armed <= 1'b0;
      bp_hit   <= 1'b0;
    end else begin
      bp_armed <= bp_armed_nxt;
      bp_hit   <= bp_hit_nxt;
    end
  end
`endif

  assign state = st;

endmodule

// File: tb/tb_clock_step_ctrl.sv
// Bench for clock_step_ctrl with N_COUNT=16; expected enable pulses are
// queued when stimulus is applied and matched as the DUT emits them.
module tb_clock_step_ctrl;

  typedef struct {
    int          cyc;
    logic [15:0] cnt;
    logic        clko;
  } pulse_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        run_btn;
  logic        step_btn;
  logic        halt_req;
  logic [1:0]  rate_sel;
  logic        cpu_en;
  logic        cpu_clk_out;
  logic [1:0]  state;
  logic [15:0] step_count;
`ifdef CLOCK_STEP_CTRL_BREAKPOINT_EN
  logic [31:0] pc_m;
  logic [31:0] bp_addr;
  logic        bp_valid;
  logic        bp_hit;
  logic        pc_load;
`endif

  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  pulse_t      exp_q[$];
  logic [15:0] exp_cnt = '0;
  logic        exp_clk = 1'b0;

  clock_step_ctrl #(.N_COUNT(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .run_btn     (run_btn),
    .step_btn    (step_btn),
    .halt_req    (halt_req),
    .rate_sel    (rate_sel),
`ifdef CLOCK_STEP_CTRL_BREAKPOINT_EN
    .pc          (pc_m),
    .bp_addr     (bp_addr),
    .bp_valid    (bp_valid),
    .bp_hit      (bp_hit),
`endif
    .cpu_en      (cpu_en),
    .cpu_clk_out (cpu_clk_out),
    .state       (state),
    .step_count  (step_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

`ifdef CLOCK_STEP_CTRL_BREAKPOINT_EN
  // Processor PC model: advances one word per enable.
  always @(posedge clk) begin
    if (pc_load) pc_m <= 32'h30;
    else if (cpu_en) pc_m <= pc_m + 32'd4;
  end
`endif

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tick_to(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic push(input int c);
    exp_cnt = exp_cnt + 16'd1;
    exp_clk = ~exp_clk;
    exp_q.push_back('{c, exp_cnt, exp_clk});
  endtask

  // Scoreboard: every enable pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst && cpu_en) begin
      pulse_t e;
      check_val("pulse_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check_val("pulse_cycle", cyc, e.cyc);
        check_val("pulse_count", 32'(step_count), 32'(e.cnt));
        check_val("pulse_clkout", 32'(cpu_clk_out), 32'(e.clko));
      end
    end
  end

  // Press run (optionally with step), expect n pulses, then halt_req in the
  // cycle where count==term so the next pulse must be suppressed.
  task automatic run_burst(input int t, input int n, input bit with_step);
    int k;
    int p;
    k = cyc;
    for (int j = 0; j < n; j++) push(k + 2 + t + j * (t + 1));
    p = k + 2 + t + n * (t + 1);
    run_btn  = 1'b1;
    step_btn = with_step;
    tick(1);
    check_val("run_entered", 32'(state), 32'd1);
    run_btn  = 1'b0;
    step_btn = 1'b0;
    tick_to(p - 1);
    halt_req = 1'b1;
    tick(1);
    check_val("halt_state", 32'(state), 32'd0);
    check_val("halt_no_pulse", 32'(cpu_en), 32'd0);
    halt_req = 1'b0;
    tick(1);
  endtask

  task automatic do_step();
    int k;
    k = cyc;
    push(k + 2);
    step_btn = 1'b1;
    tick(1);
    check_val("step_state", 32'(state), 32'd2);
    tick(1);
    check_val("step_back_halt", 32'(state), 32'd0);
    tick(8);
    step_btn = 1'b0;
    tick(2);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rst = 1'b0;
    run_btn = 1'b0;
    step_btn = 1'b0;
    halt_req = 1'b0;
    rate_sel = 2'd0;
`ifdef CLOCK_STEP_CTRL_BREAKPOINT_EN
    bp_addr = '0;
    bp_valid = 1'b0;
    pc_load = 1'b1;
`endif
    tick(3);
    check_val("rst_state", 32'(state), 32'd0);
    check_val("rst_cpu_en", 32'(cpu_en), 32'd0);
    check_val("rst_clkout", 32'(cpu_clk_out), 32'd0);
    check_val("rst_count", 32'(step_count), 32'd0);
    rst = 1'b1;
`ifdef CLOCK_STEP_CTRL_BREAKPOINT_EN
    pc_load = 1'b0;
`endif
    tick(2);

    // Single step, button held: exactly one pulse.
    do_step();
    check_val("step_count_one", 32'(step_count), 32'd1);

    // halt_req during the STEP cycle cancels the pulse.
    step_btn = 1'b1;
    tick(1);
    check_val("step_cancel_state", 32'(state), 32'd2);
    halt_req = 1'b1;
    tick(1);
    check_val("step_cancel_halt", 32'(state), 32'd0);
    check_val("step_cancel_pulse", 32'(cpu_en), 32'd0);
    halt_req = 1'b0;
    step_btn = 1'b0;
    tick(2);

    // Buttons ignored while halt_req is held.
    halt_req = 1'b1;
    run_btn = 1'b1;
    tick(1);
    check_val("halt_req_run", 32'(state), 32'd0);
    run_btn = 1'b0;
    step_btn = 1'b1;
    tick(2);
    check_val("halt_req_step", 32'(state), 32'd0);
    step_btn = 1'b0;
    halt_req = 1'b0;
    tick(2);
    check_val("halt_req_after", 32'(state), 32'd0);

    // Divider periods for every rate select.
    for (int s = 0; s < 4; s++) begin
      rate_sel = 2'(s);
      run_burst(16 >> (2 * s), 3, 1'b0);
    end

    // Run and step together: run wins, no step pulse.
    rate_sel = 2'd1;
    run_burst(4, 2, 1'b1);

    // Rate change while count is above the new terminal count.
    rate_sel = 2'd0;
    k = cyc;
    run_btn = 1'b1;
    tick(1);
    run_btn = 1'b0;
    tick_to(k + 11);
    push(k + 12);
    push(k + 13);
    push(k + 14);
    rate_sel = 2'd3;
    tick_to(k + 14);
    halt_req = 1'b1;
    tick(1);
    check_val("rate_change_halt", 32'(state), 32'd0);
    halt_req = 1'b0;
    tick(1);

`ifdef CLOCK_STEP_CTRL_BREAKPOINT_EN
    // Breakpoint at 0x40, then resume past it to a second match at 0x4C.
    rate_sel = 2'd2;
    bp_addr = 32'h40;
    bp_valid = 1'b1;
    pc_load = 1'b1;
    tick(1);
    pc_load = 1'b0;
    k = cyc;
    push(k + 3);
    push(k + 5);
    push(k + 7);
    push(k + 9);
    run_btn = 1'b1;
    tick(1);
    check_val("bp_run", 32'(state), 32'd1);
    run_btn = 1'b0;
    tick_to(k + 11);
    check_val("bp_halt", 32'(state), 32'd0);
    check_val("bp_hit_set", 32'(bp_hit), 32'd1);
    check_val("bp_no_pulse", 32'(cpu_en), 32'd0);
    bp_addr = 32'h4C;
    tick(1);
    k = cyc;
    push(k + 3);
    push(k + 5);
    push(k + 7);
    run_btn = 1'b1;
    tick(1);
    check_val("bp_resume", 32'(state), 32'd1);
    check_val("bp_hit_clear", 32'(bp_hit), 32'd0);
    run_btn = 1'b0;
    tick_to(k + 3);
    check_val("bp_advance", 32'(state), 32'd1);
    tick_to(k + 9);
    check_val("bp_halt2", 32'(state), 32'd0);
    check_val("bp_hit2", 32'(bp_hit), 32'd1);
    bp_valid = 1'b0;
    tick(2);
`endif

    // Reset in the middle of RUN, with step held across reset release.
    rate_sel = 2'd1;
    k = cyc;
    push(k + 6);
    run_btn = 1'b1;
    tick(1);
    run_btn = 1'b0;
    tick_to(k + 10);
    rst = 1'b0;
    step_btn = 1'b1;
    tick(1);
    check_val("midrst_state", 32'(state), 32'd0);
    check_val("midrst_cpu_en", 32'(cpu_en), 32'd0);
    check_val("midrst_clkout", 32'(cpu_clk_out), 32'd0);
    check_val("midrst_count", 32'(step_count), 32'd0);
    exp_cnt = '0;
    exp_clk = 1'b0;
    tick(1);
    rst = 1'b1;
    tick(4);
    check_val("held_btn_no_step", 32'(state), 32'd0);
    step_btn = 1'b0;
    tick(2);
    do_step();
    check_val("step_after_rst", 32'(step_count), 32'd1);

    // Counter wrap: run at full rate past 0xFFFF.
    rate_sel = 2'd3;
    run_burst(0, 65538 - int'(exp_cnt), 1'b0);
    check_val("wrap_count", 32'(step_count), 32'd2);

    tick(3);
    check_val("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/clock_step_ctrl.md
Name: clock_step_ctrl

Overview:
Run/step/halt controller for the MIPS processor clock on the FPGA board.
- Sequences processor advancement by issuing one-cycle cpu_en pulses from a programmable-rate divider (RUN), single pulses per button press (STEP), or none (HALT).
- Provides a visible square wave and a cycle counter for board LEDs/7-seg.
- Sits between board buttons/switches and the processor's clock-enable input.

Parameters:
- N_COUNT, 25000000, base divider terminal count at rate_sel=0.
- PC_WIDTH, 32, width of pc/bp_addr (used only with BREAKPOINT_EN).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-low reset.
- run_btn  in  1  debounced level; rising edge toggles RUN/HALT.
- step_btn  in  1  debounced level; rising edge requests one step while halted.
- halt_req  in  1  level; forces HALT; highest priority.
- rate_sel  in  2  divider select; term = N_COUNT >> (2*rate_sel).
- cpu_en  out  1  one-cycle processor clock enable.
- cpu_clk_out  out  1  toggles on every cpu_en pulse (LED indicator).
- state  out  2  current FSM state: HALT=0, RUN=1, STEP=2.
- step_count  out  16  number of cpu_en pulses issued; wraps.

Behaviour:
- Reset, when rst=0 at posedge clk:
  - state=HALT, divider count=0, cpu_en=0, cpu_clk_out=0, step_count=0.
  - Edge-detect history registers=0.
  - Applies mid-RUN/STEP identically; no pulse is issued in the reset cycle.
- Edge detect: rise = btn & ~btn_d, where btn_d is registered each cycle. A button already high at reset release produces no edge until it is released and pressed again.
- HALT:
  - halt_req=1 → stay HALT.
  - Else run rise → RUN (count cleared to 0).
  - Else step rise → STEP.
  - Run and step rising together → RUN; the step edge is discarded.
- STEP: lasts exactly one cycle. At its closing edge: cpu_en<=1, state<=HALT. The step edge is seen in cycle t, so cpu_en is high in cycle t+2. halt_req in the STEP cycle → HALT with no pulse.
- RUN, each cycle:
  - halt_req=1 or run rise → HALT, count<=0, no pulse (wins over terminal).
  - Else if count >= term → count<=0, cpu_en<=1.
  - Else count<=count+1, cpu_en<=0.
  - Pulse period is term+1 cycles; term=0 gives cpu_en every cycle.
  - rate_sel may change at any time; term is recomputed combinationally. If count already exceeds the new term, the pulse occurs at the next edge (>= compare).
- cpu_en is registered; it is high for exactly one cycle per pulse and never for two consecutive cycles in STEP mode.
- On every cycle cpu_en<=1: cpu_clk_out toggles and step_count<=step_count+1 (0xFFFF→0x0000).
- state output is registered FSM state; the encoding is stable (used by the 7-seg decoder).

Optional Feature:
- Macro CLOCK_STEP_CTRL_BREAKPOINT_EN.
- With macro, adds ports: pc in PC_WIDTH, bp_addr in PC_WIDTH, bp_valid in 1, bp_hit out 1 (reset 0).
  - In RUN, bp_valid & (pc==bp_addr) → HALT next edge, no pulse, bp_hit<=1.
  - bp_hit is sticky; it clears on the edge leaving HALT.
  - The breakpoint check is armed only after the first cpu_en since entering RUN, so resuming from a breakpoint PC advances.
  - STEP ignores the breakpoint. halt_req has priority over the breakpoint; bp_hit is set only if the breakpoint caused the halt.
- Without macro: those ports and all compare logic are absent; behaviour is otherwise identical.

Decomposition:
- Package clock_ctrl_pkg:
  - typedef ctrl_state_t (2-bit enum HALT=0, RUN=1, STEP=2).
  - STEP_CNT_W=16.
  - RATE_SHIFT=2.
- Sub-module rise_detect (registered history plus rising-edge output, active-low sync reset), instantiated for run_btn and step_btn.

Test Plan:
- N_COUNT=16, reset then run_btn pulse → state=1. cpu_en pulses every 17 cycles at rate_sel=0, every 5 at 1, every 2 at 2, every cycle at 3. cpu_clk_out toggles per pulse.
- From HALT, step_btn rise in cycle t → exactly one cpu_en at t+2, state back to 0, step_count=1. Holding step_btn high gives no further pulses.
- RUN with halt_req asserted in the same cycle count==term → no cpu_en, state=0, count=0. Pressing run/step while halt_req=1 → stays HALT.
- run_btn and step_btn rise together in HALT → RUN, no step pulse. rst=0 mid-RUN → all outputs 0 next cycle. Preset 0xFFFF pulses → step_count wraps to 0.
- rate_sel 0→3 mid-count (count=10) → cpu_en on the very next edge.
- BREAKPOINT_EN: bp_addr=0x40, pc reaches 0x40 in RUN → HALT, bp_hit=1. Resume via run_btn → bp_hit=0, one pulse advances past 0x40, and a later match halts again.
